// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with pending-write scoreboard; optional write-to-read forwarding under REGFILE_BYPASS_EN
module regfile_mp #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NWRITE-1:0]       wen,
  input  logic [NWRITE*AW-1:0]    wsel,
  input  logic [NWRITE*WIDTH-1:0] wdat,
  input  logic [NREAD*AW-1:0]     rsel,
  output logic [NREAD*WIDTH-1:0]  rdat,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_sel,
  input  logic                    flush,
  output logic [AW:0]             pend_cnt
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic [AW:0]      r_cnt;
  logic [DEPTH-1:0] w_pend_nxt;
  logic [AW:0]      w_cnt_nxt;

  // storage writes; later ports overwrite earlier ones, register 0 never written
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int k = 0; k < NWRITE; k++)
        if (wen[k] && wsel[k*AW +: AW] != '0) r_mem[wsel[k*AW +: AW]] <= wdat[k*WIDTH +: WIDTH];
    end
  end

  // pending next state: writeback clears, issue sets over it, flush clears everything
  always_comb begin
    w_pend_nxt = r_pend;
    for (int k = 0; k < NWRITE; k++)
      if (wen[k]) w_pend_nxt[wsel[k*AW +: AW]] = 1'b0;
    if (iss_en) w_pend_nxt[iss_sel] = 1'b1;
    w_pend_nxt[0] = 1'b0;
    if (flush) w_pend_nxt = '0;
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_pend_nxt[i]};
  end

  // pending vector and its popcount register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign pend_cnt = r_cnt;

  // combinational read ports, optionally forwarded from same-cycle writes
  always_comb begin
    rdat  = '0;
    rbusy = '0;
    for (int j = 0; j < NREAD; j++) begin
      rdat[j*WIDTH +: WIDTH] = r_mem[rsel[j*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWRITE; k++)
        if (wen[k] && wsel[k*AW +: AW] == rsel[j*AW +: AW] && rsel[j*AW +: AW] != '0)
          rdat[j*WIDTH +: WIDTH] = wdat[k*WIDTH +: WIDTH];
      rbusy[j] = iss_en && iss_sel == rsel[j*AW +: AW] && rsel[j*AW +: AW] != '0;
`else
      rbusy[j] = r_pend[rsel[j*AW +: AW]];
`endif
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against an array-based reference model
module tb_regfile_mp;
  localparam int W = 32, D = 32, NR = 2, NW = 2, AW = 5;
  logic CLK = 1'b0, nRST;
  logic [NW-1:0] wen;
  logic [NW*AW-1:0] wsel;
  logic [NW*W-1:0] wdat;
  logic [NR*AW-1:0] rsel;
  logic [NR*W-1:0] rdat;
  logic [NR-1:0] rbusy;
  logic iss_en;
  logic [AW-1:0] iss_sel;
  logic flush;
  logic [AW:0] pend_cnt;
  logic [W-1:0] m_mem [D];
  bit m_pend [D];
  int total = 0, bad = 0;

  regfile_mp dut (.CLK(CLK), .nRST(nRST), .wen(wen), .wsel(wsel), .wdat(wdat), .rsel(rsel),
                  .rdat(rdat), .rbusy(rbusy), .iss_en(iss_en), .iss_sel(iss_sel), .flush(flush),
                  .pend_cnt(pend_cnt));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_rd(int j);
    logic [AW-1:0] a = rsel[j*AW +: AW];
    exp_rd = m_mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int k = 0; k < NW; k++)
      if (wen[k] && wsel[k*AW +: AW] == a && a != 0) exp_rd = wdat[k*W +: W];
`endif
  endfunction

  function automatic logic exp_bz(int j);
    logic [AW-1:0] a = rsel[j*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    exp_bz = iss_en && iss_sel == a && a != 0;
`else
    exp_bz = m_pend[a];
`endif
  endfunction

  function automatic int m_cnt();
    m_cnt = 0;
    for (int i = 0; i < D; i++) m_cnt += int'(m_pend[i]);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < D; i++) begin
      m_mem[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic m_update();
    for (int k = 0; k < NW; k++)
      if (wen[k] && wsel[k*AW +: AW] != 0) m_mem[wsel[k*AW +: AW]] = wdat[k*W +: W];
    if (flush) begin
      for (int i = 0; i < D; i++) m_pend[i] = 1'b0;
    end else begin
      for (int k = 0; k < NW; k++) if (wen[k]) m_pend[wsel[k*AW +: AW]] = 1'b0;
      if (iss_en && iss_sel != 0) m_pend[iss_sel] = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    for (int j = 0; j < NR; j++) begin
      chk($sformatf("%s rdat%0d", tag, j), 64'(rdat[j*W +: W]), 64'(exp_rd(j)));
      chk($sformatf("%s rbusy%0d", tag, j), 64'(rbusy[j]), 64'(exp_bz(j)));
    end
    chk({tag, " pend_cnt"}, 64'(pend_cnt), 64'(m_cnt()));
  endtask

  task automatic idle();
    wen = '0;
    iss_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic set_w(input int k, input logic [AW-1:0] s, input logic [W-1:0] d);
    wen[k] = 1'b1;
    wsel[k*AW +: AW] = s;
    wdat[k*W +: W] = d;
  endtask

  task automatic step(input string tag);
    #1 check_all(tag);
    @(posedge CLK);
    m_update();
    @(negedge CLK);
  endtask

  initial begin
    m_reset();
    nRST = 1'b0;
    idle();
    wsel = '0;
    wdat = '0;
    rsel = '0;
    iss_sel = '0;
    set_w(0, 5'd5, 32'h1111_1111);
    set_w(1, 5'd6, 32'h2222_2222);
    rsel = {5'd6, 5'd5};
    repeat (2) @(posedge CLK);
    #1;
    chk("rst rdat0", 64'(rdat[W-1:0]), 64'h0);
    chk("rst rdat1", 64'(rdat[2*W-1:W]), 64'h0);
    chk("rst rbusy", 64'(rbusy), 64'h0);
    chk("rst pend_cnt", 64'(pend_cnt), 64'h0);
    @(negedge CLK);
    nRST = 1'b1;
    idle();
    step("post_rst");
    set_w(0, 5'd7, 32'h5555_0000);
    set_w(1, 5'd7, 32'hAAAA_0001);
    step("collide");
    idle();
    rsel[AW-1:0] = 5'd7;
    #1 chk("collide port1 wins", 64'(rdat[W-1:0]), 64'hAAAA_0001);
    step("collide rd");
    set_w(0, 5'd0, 32'hFFFF_FFFF);
    iss_en = 1'b1;
    iss_sel = 5'd0;
    rsel[AW-1:0] = 5'd0;
    step("reg0");
    idle();
    #1;
    chk("reg0 rdat", 64'(rdat[W-1:0]), 64'h0);
    chk("reg0 rbusy", 64'(rbusy[0]), 64'h0);
    chk("reg0 pend_cnt", 64'(pend_cnt), 64'h0);
    iss_en = 1'b1;
    iss_sel = 5'd3;
    step("iss3");
    iss_sel = 5'd9;
    step("iss9");
    idle();
    rsel = {5'd9, 5'd3};
    #1;
    chk("sb cnt2", 64'(pend_cnt), 64'd2);
    chk("sb busy3", 64'(rbusy[0]), 64'd1);
    set_w(0, 5'd3, 32'h1234);
    step("wb3");
    idle();
    #1;
    chk("sb busy3 clr", 64'(rbusy[0]), 64'd0);
    chk("sb cnt1", 64'(pend_cnt), 64'd1);
    iss_en = 1'b1;
    iss_sel = 5'd9;
    set_w(0, 5'd9, 32'h9999);
    step("iss_wb9");
    idle();
    #1 chk("sb busy9 held", 64'(rbusy[1]), 64'd1);
    flush = 1'b1;
    step("flush");
    idle();
    #1 chk("sb flushed", 64'(pend_cnt), 64'd0);
    set_w(0, 5'd12, 32'hDEAD_BEEF);
    rsel[AW-1:0] = 5'd12;
`ifdef REGFILE_BYPASS_EN
    #1 chk("bypass pre", 64'(rdat[W-1:0]), 64'hDEAD_BEEF);
`else
    #1 chk("bypass pre", 64'(rdat[W-1:0]), 64'h0);
`endif
    step("bypass");
    idle();
    #1 chk("bypass post", 64'(rdat[W-1:0]), 64'hDEAD_BEEF);
    for (int n = 0; n < 400; n++) begin
      wen = NW'($urandom_range(0, 3));
      for (int k = 0; k < NW; k++) begin
        wsel[k*AW +: AW] = AW'($urandom_range(0, 15));
        wdat[k*W +: W] = $urandom;
      end
      for (int j = 0; j < NR; j++) rsel[j*AW +: AW] = AW'($urandom_range(0, 15));
      iss_en = ($urandom_range(0, 2) != 0);
      iss_sel = AW'($urandom_range(0, 15));
      flush = ($urandom_range(0, 40) == 0);
      step("rand");
    end
    idle();
    flush = 1'b1;
    step("pre_arst flush");
    idle();
    set_w(0, 5'd20, 32'hCAFE_0020);
    set_w(1, 5'd21, 32'hCAFE_0021);
    step("pre_arst wr");
    idle();
    for (int r = 1; r <= 4; r++) begin
      iss_en = 1'b1;
      iss_sel = AW'(r);
      step("pre_arst iss");
    end
    idle();
    rsel = {5'd21, 5'd20};
    #1 chk("pre_arst cnt4", 64'(pend_cnt), 64'd4);
    @(posedge CLK);
    #3 nRST = 1'b0;
    #1;
    chk("arst pend_cnt", 64'(pend_cnt), 64'h0);
    chk("arst rdat0", 64'(rdat[W-1:0]), 64'h0);
    chk("arst rdat1", 64'(rdat[2*W-1:W]), 64'h0);
    chk("arst rbusy", 64'(rbusy), 64'h0);
    m_reset();
    @(negedge CLK);
    nRST = 1'b1;
    step("post_arst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
